// File: rtl/rgbw_pkg.sv
// Shared constants and state encoding for the RGBW frame decoder.
// Frame layout: sync, six payload bytes, tail.
package rgbw_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;
  localparam logic [7:0] DEF_TAIL_BYTE = 8'hA4;

  localparam int PAYLOAD_LEN = 6;

  localparam int IDX_MODE  = 0;
  localparam int IDX_LUM   = 1;
  localparam int IDX_RED   = 2;
  localparam int IDX_GREEN = 3;
  localparam int IDX_BLUE  = 4;
  localparam int IDX_WHITE = 5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    TAIL    = 2'd2
  } state_t;

endpackage

// File: rtl/rgbw_gap_timer.sv
// Saturating inter-byte gap counter; expire flags the cycle in which a
// frame has waited too long for its next byte.
module rgbw_gap_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk12,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || !enable) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + W'(1);
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Hunts for sync/payload/tail frames in the SPI byte stream and commits
// the six payload bytes to the outputs atomically on a good tail.
module rgbw_frame_decoder
  import rgbw_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  TAIL_BYTE      = DEF_TAIL_BYTE
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [7:0] mode,
  output logic [7:0] lum,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] shadow_reg [PAYLOAD_LEN];
  logic [7:0] out_reg    [PAYLOAD_LEN];
  logic       frame_valid_reg, frame_err_reg;
  logic       shadow_we, commit, err, expire;

  rgbw_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk12  (clk12),
    .reset  (reset),
    .clear  (rx_rdy),
    .enable (state_reg != HUNT),
    .expire (expire)
  );

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      state_reg       <= HUNT;
      idx_reg         <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      frame_valid_reg <= commit;
      frame_err_reg   <= err;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    case (state_reg)
      HUNT: begin
        if (rx_rdy && rx_data == SYNC_BYTE) begin
          state_next = PAYLOAD;
          idx_next   = '0;
        end
      end
      PAYLOAD: begin
        // Sync-valued bytes here are ordinary payload data.
        if (rx_rdy) begin
          shadow_we = 1'b1;
          if (idx_reg == 3'(IDX_WHITE)) state_next = TAIL;
          else                          idx_next   = idx_reg + 3'd1;
        end else if (expire) begin
          err        = 1'b1;
          state_next = HUNT;
        end
      end
      TAIL: begin
        if (rx_rdy) begin
          state_next = HUNT;
          if (rx_data == TAIL_BYTE) commit = 1'b1;
          else                      err    = 1'b1;
        end else if (expire) begin
          err        = 1'b1;
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        shadow_reg[i] <= '0;
        out_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        if (shadow_we && idx_reg == 3'(i)) shadow_reg[i] <= rx_data;
        if (commit)                        out_reg[i]    <= shadow_reg[i];
      end
    end
  end

  assign mode        = out_reg[IDX_MODE];
  assign lum         = out_reg[IDX_LUM];
  assign red         = out_reg[IDX_RED];
  assign green       = out_reg[IDX_GREEN];
  assign blue        = out_reg[IDX_BLUE];
  assign white       = out_reg[IDX_WHITE];
  assign frame_valid = frame_valid_reg;
  assign frame_err   = frame_err_reg;
  assign busy        = (state_reg != HUNT);

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Directed bench for rgbw_frame_decoder: a queue-based frame model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_rgbw_frame_decoder;

  localparam int T = 4096;

  logic       clk12 = 1'b0;
  logic       reset = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] mode, lum, red, green, blue, white;
  logic       frame_valid, frame_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  rgbw_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk12       (clk12),
    .reset       (reset),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .mode        (mode),
    .lum         (lum),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .white       (white),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk12 = ~clk12;

  // Model: collected bytes after sync, edges since the last byte.
  logic [7:0] q[$];
  bit         in_frame = 0;
  int         gap = 0;
  logic [7:0] m_out [6] = '{default: 8'h00};
  bit         ev = 0, ee = 0;

  always @(posedge clk12 or posedge reset) begin
    if (reset) begin
      q.delete();
      in_frame = 0;
      gap = 0;
      for (int i = 0; i < 6; i++) m_out[i] = 8'h00;
      ev = 0;
      ee = 0;
    end else begin
      ev = 0;
      ee = 0;
      if (!in_frame) begin
        if (rx_rdy && rx_data == 8'h55) begin
          in_frame = 1;
          gap = 0;
          q.delete();
        end
      end else if (rx_rdy) begin
        gap = 0;
        q.push_back(rx_data);
        if (q.size() == 7) begin
          if (q[6] == 8'hA4) begin
            for (int i = 0; i < 6; i++) m_out[i] = q[i];
            ev = 1;
          end else begin
            ee = 1;
          end
          in_frame = 0;
        end
      end else begin
        gap++;
        if (gap == T) begin
          ee = 1;
          in_frame = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk12) begin
    chk("mode", mode, m_out[0]);
    chk("lum", lum, m_out[1]);
    chk("red", red, m_out[2]);
    chk("green", green, m_out[3]);
    chk("blue", blue, m_out[4]);
    chk("white", white, m_out[5]);
    chk("frame_valid", {7'd0, frame_valid}, {7'd0, ev});
    chk("frame_err", {7'd0, frame_err}, {7'd0, ee});
    chk("busy", {7'd0, busy}, {7'd0, in_frame});
    if (frame_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk12);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk12);
    #2;
    rx_rdy  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input int spacing);
    for (int i = 0; i < 8; i++) begin
      send(f[63-8*i -: 8]);
      if (spacing > 1) idle(spacing - 1);
    end
    $display("frame %h sent, spacing %0d", f, spacing);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);
    @(negedge clk12);
    chk("reset_lum", lum, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    idle(1);

    send_frame(64'h55_00_24_00_FF_00_00_A4, 80);
    idle(5);
    chk("valid_lum", lum, 8'h24);
    chk("valid_green", green, 8'hFF);
    chk("valid_count1", 8'(valid_seen), 8'd1);

    send_frame(64'h55_00_23_00_FF_00_00_A5, 80);
    idle(5);
    chk("badtail_err", 8'(err_seen), 8'd1);
    chk("badtail_lum", lum, 8'h24);
    chk("badtail_valid", 8'(valid_seen), 8'd1);

    send(8'h55); idle(79);
    send(8'h01); idle(79);
    send(8'h02);
    idle(T + 10);
    $display("timeout gap of %0d cycles done", T + 10);
    chk("timeout_err", 8'(err_seen), 8'd2);
    chk("timeout_busy", {7'd0, busy}, 8'h00);
    send_frame(64'h55_00_23_00_FF_00_00_A4, 80);
    idle(5);
    chk("after_timeout_lum", lum, 8'h23);
    chk("valid_count2", 8'(valid_seen), 8'd2);

    send(8'h00); idle(10);
    send(8'h13); idle(10);
    send_frame(64'h55_55_10_20_30_40_50_A4, 20);
    idle(5);
    chk("garbage_no_err", 8'(err_seen), 8'd2);
    chk("embsync_mode", mode, 8'h55);
    chk("embsync_white", white, 8'h50);
    chk("valid_count3", 8'(valid_seen), 8'd3);

    send(8'h55); send(8'h01); send(8'h02); send(8'h03);
    idle(2);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    $display("reset applied mid-frame");
    chk("midreset_mode", mode, 8'h00);
    chk("midreset_busy", {7'd0, busy}, 8'h00);
    send(8'h04); send(8'h05); send(8'h06); send(8'hA4);
    idle(10);
    chk("midreset_no_valid", 8'(valid_seen), 8'd3);
    chk("midreset_no_err", 8'(err_seen), 8'd2);

    send(8'h55); send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66); send(8'hA4);
    @(negedge clk12);
    chk("b2b_valid_pulse", {7'd0, frame_valid}, 8'h01);
    chk("b2b_red", red, 8'h33);
    @(negedge clk12);
    chk("b2b_valid_one_cycle", {7'd0, frame_valid}, 8'h00);
    $display("back-to-back frame sent");
    idle(5);
    chk("valid_count4", 8'(valid_seen), 8'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgbw_frame_decoder.md
# rgbw_frame_decoder

Byte-stream frame decoder between the SPI slave receiver and the RGBW colour/PWM datapath of `rgbw_lamp`. It consumes one-cycle byte strobes from the SPI slave and hunts for an 8-byte frame: sync 0x55, mode, luminosity, red, green, blue, white, tail 0xA4. Each valid frame is committed atomically to output registers, so the PWM stage never sees a partially updated colour set. Malformed or stalled frames are discarded and flagged.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum number of `clk12` cycles allowed between consecutive bytes inside a frame.
- `SYNC_BYTE`, default 8'h55: frame start marker.
- `TAIL_BYTE`, default 8'hA4: frame end marker.

Ports:
- `clk12`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_rdy`  in  1  one-cycle strobe from the SPI slave; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte.
- `mode`  out  8  committed mode byte.
- `lum`  out  8  committed luminosity.
- `red`, `green`, `blue`, `white`  out  8 each  committed channel levels.
- `frame_valid`  out  1  one-cycle pulse on commit.
- `frame_err`  out  1  one-cycle pulse on bad tail or timeout.
- `busy`  out  1  high while a frame is in progress (any state other than HUNT).

## Operation
- States:
  - HUNT: wait for the sync byte.
  - PAYLOAD: collect 6 bytes, tracked by an index 0..5.
  - TAIL: expect the tail byte.
- HUNT:
  - `rx_rdy` with `rx_data == SYNC_BYTE` → PAYLOAD, index = 0, gap timer cleared.
  - Any other byte is ignored silently; no error.
- PAYLOAD:
  - On each `rx_rdy`, store `rx_data` into shadow register [index] (order: mode, lum, R, G, B, W) and increment the index.
  - Storing index 5 → TAIL.
  - A byte equal to 0x55 inside the payload is data, not a resync.
- TAIL:
  - `rx_data == TAIL_BYTE` → copy all six shadow registers to the outputs in one cycle, pulse `frame_valid`, go to HUNT.
  - Any other value → pulse `frame_err`, go to HUNT, leave outputs unchanged. The offending byte is not re-examined as a sync byte.
- Gap timeout:
  - Outside HUNT, a counter increments on every cycle without `rx_rdy` and clears on `rx_rdy`.
  - When it reaches `TIMEOUT_CYCLES - 1` → pulse `frame_err`, go to HUNT, outputs unchanged.
  - If `rx_rdy` arrives in the same cycle the timeout would fire, the byte wins: it is processed and the counter clears.
- CS behaviour: the chip-select level is not an input. Bytes may arrive with CS toggled between them; only the gap timer bounds a frame.
- `frame_valid` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset:
  - Asserting `reset` forces HUNT immediately, including mid-frame.
  - All outputs reset to 0: `mode`, `lum`, `red`, `green`, `blue`, `white`, `frame_valid`, `frame_err`, `busy`.
  - Shadow registers and the gap counter also reset to 0.
- Latency:
  - The tail-byte strobe sampled at edge k updates all outputs and raises `frame_valid` after edge k, i.e. visible in cycle k+1 (one clock).
  - `frame_valid` lasts exactly one cycle.
- `busy` rises the cycle after sync is accepted and falls in the same cycle as the `frame_valid` or `frame_err` pulse.
- Back-to-back `rx_rdy` strobes on consecutive cycles must be accepted with no loss.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter saturates and never wraps.

## Structure
- Shared package `rgbw_pkg`:
  - Default sync and tail constants.
  - `PAYLOAD_LEN = 6`.
  - Payload index names (IDX_MODE … IDX_WHITE).
  - State encoding (HUNT, PAYLOAD, TAIL).
- One sub-module, `rgbw_gap_timer`: saturating counter with clear, enable and expire outputs, parameterised by `TIMEOUT_CYCLES`.
- The FSM, shadow registers and output registers stay in `rgbw_frame_decoder`.

## Test plan
- Valid frame: bytes 55 00 24 00 FF 00 00 A4, one byte every 80 cycles → one `frame_valid` pulse; outputs `mode`=00, `lum`=24, `red`=00, `green`=FF, `blue`=00, `white`=00.
- Bad tail: 55 00 23 00 FF 00 00 A5 after the valid frame above → `frame_err` pulse; outputs still hold the previous frame (`lum`=24).
- Timeout: 55 01 02, then silence for `TIMEOUT_CYCLES` → `frame_err` pulse; `busy` falls. A following valid frame with `lum`=23 commits correctly.
- Garbage and embedded sync:
  - Bytes 00 13 before the sync are ignored: no `frame_err`.
  - Frame 55 55 10 20 30 40 50 A4 → `mode`=55, `lum`=10, `red`=20, `green`=30, `blue`=40, `white`=50.
- Reset mid-frame: assert `reset` after the third payload byte → all outputs 0, HUNT. The remaining bytes (no sync) produce no pulse.
- Back-to-back strobes: all 8 bytes on consecutive cycles → `frame_valid` exactly one cycle after the A4 strobe.
